// File: rtl/axi_rab_w_sched_pkg.sv
// Shared types for the AXI4 W-channel order scheduler: FSM states, order-FIFO entry, burst limits.
package axi_rab_w_sched_pkg;

  localparam int unsigned AXI_MAX_BEATS  = 256;
  localparam int unsigned BEAT_CNT_W     = 9;
  // Port field is sized for the largest supported port count; users truncate to PORT_W.
  localparam int unsigned W_SCHED_PORT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } w_sched_state_t;

  typedef struct packed {
    logic                      drop;
    logic [W_SCHED_PORT_W-1:0] port;
  } w_order_entry_t;

endpackage

// File: rtl/axi4_w_order_fifo.sv
// Synchronous FIFO of AW-order entries; push is ignored when full, pop when empty.
module axi4_w_order_fifo
  import axi_rab_w_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  w_order_entry_t push_data,
  input  logic           pop,
  output w_order_entry_t pop_data_c,
  output logic           full_c,
  output logic           empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  w_order_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_c     = (count == CNT_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign do_push    = push & ~full_c;
  assign do_pop     = pop & ~empty_c;
  assign pop_data_c = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi4_w_order_sched.sv
// Forwards or drains one W burst per AW-order entry, in grant order, onto the shared master W channel.
module axi4_w_order_sched
  import axi_rab_w_sched_pkg::*;
#(
  parameter int unsigned N_PORTS        = 4,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_USER_WIDTH = 2,
  parameter int unsigned ORDER_DEPTH    = 8,
  parameter int unsigned PORT_W         = $clog2(N_PORTS)
) (
  input  logic                                  axi4_aclk,
  input  logic                                  axi4_arstn,
  input  logic                                  aw_push_valid,
  input  logic [PORT_W-1:0]                     aw_push_port,
  input  logic                                  aw_push_drop,
  output logic                                  aw_push_ready,
  input  logic [N_PORTS*AXI_DATA_WIDTH-1:0]     s_axi4_wdata,
  input  logic [N_PORTS*AXI_DATA_WIDTH/8-1:0]   s_axi4_wstrb,
  input  logic [N_PORTS*AXI_USER_WIDTH-1:0]     s_axi4_wuser,
  input  logic [N_PORTS-1:0]                    s_axi4_wlast,
  input  logic [N_PORTS-1:0]                    s_axi4_wvalid,
  output logic [N_PORTS-1:0]                    s_axi4_wready,
  output logic [AXI_DATA_WIDTH-1:0]             m_axi4_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]           m_axi4_wstrb,
  output logic [AXI_USER_WIDTH-1:0]             m_axi4_wuser,
  output logic                                  m_axi4_wlast,
  output logic                                  m_axi4_wvalid,
  input  logic                                  m_axi4_wready,
  output logic                                  burst_done,
  output logic [PORT_W-1:0]                     burst_done_port,
  output logic                                  protocol_err
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  w_sched_state_t          state;
  logic [PORT_W-1:0]       cur_port;
  logic [BEAT_CNT_W-1:0]   beat_cnt;

  w_order_entry_t          push_entry_c;
  w_order_entry_t          head_c;
  logic                    fifo_full_c;
  logic                    fifo_empty_c;
  logic                    fifo_pop_c;

  logic [AXI_DATA_WIDTH-1:0] sel_data_c;
  logic [STRB_W-1:0]         sel_strb_c;
  logic [AXI_USER_WIDTH-1:0] sel_user_c;
  logic                      sel_last_c;
  logic                      sel_valid_c;
  logic                      beat_hs_c;

  assign push_entry_c.drop = aw_push_drop;
  assign push_entry_c.port = W_SCHED_PORT_W'(aw_push_port);
  assign aw_push_ready     = ~fifo_full_c;
  assign fifo_pop_c        = (state == IDLE) & ~fifo_empty_c;

  axi4_w_order_fifo #(
    .DEPTH (ORDER_DEPTH)
  ) u_order_fifo (
    .clk        (axi4_aclk),
    .rst_n      (axi4_arstn),
    .push       (aw_push_valid),
    .push_data  (push_entry_c),
    .pop        (fifo_pop_c),
    .pop_data_c (head_c),
    .full_c     (fifo_full_c),
    .empty_c    (fifo_empty_c)
  );

  // Select the current port's W fields.
  always_comb begin
    sel_data_c  = '0;
    sel_strb_c  = '0;
    sel_user_c  = '0;
    sel_last_c  = 1'b0;
    sel_valid_c = 1'b0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (PORT_W'(p) == cur_port) begin
        sel_data_c  = s_axi4_wdata[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        sel_strb_c  = s_axi4_wstrb[p*STRB_W +: STRB_W];
        sel_user_c  = s_axi4_wuser[p*AXI_USER_WIDTH +: AXI_USER_WIDTH];
        sel_last_c  = s_axi4_wlast[p];
        sel_valid_c = s_axi4_wvalid[p];
      end
    end
  end

  // Master W path and slave readies; idle and drop keep the master side quiet.
  always_comb begin
    m_axi4_wdata  = '0;
    m_axi4_wstrb  = '0;
    m_axi4_wuser  = '0;
    m_axi4_wlast  = 1'b0;
    m_axi4_wvalid = 1'b0;
    s_axi4_wready = '0;
    beat_hs_c     = 1'b0;
    case (state)
      FWD: begin
        m_axi4_wdata  = sel_data_c;
        m_axi4_wstrb  = sel_strb_c;
        m_axi4_wuser  = sel_user_c;
        m_axi4_wlast  = sel_last_c;
        m_axi4_wvalid = sel_valid_c;
        s_axi4_wready = N_PORTS'(m_axi4_wready) << cur_port;
        beat_hs_c     = sel_valid_c & m_axi4_wready;
      end
      DROP: begin
        s_axi4_wready = N_PORTS'(1) << cur_port;
        beat_hs_c     = sel_valid_c;
      end
      default: begin
        beat_hs_c = 1'b0;
      end
    endcase
  end

  // Burst sequencing, beat counting and completion pulse.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state           <= IDLE;
      cur_port        <= '0;
      beat_cnt        <= '0;
      burst_done      <= 1'b0;
      burst_done_port <= '0;
      protocol_err    <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop_c) begin
            cur_port <= PORT_W'(head_c.port);
            beat_cnt <= '0;
            state    <= head_c.drop ? DROP : FWD;
          end
        end
        FWD, DROP: begin
          if (beat_hs_c) begin
            if (beat_cnt != BEAT_CNT_W'(AXI_MAX_BEATS)) begin
              beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
            // A non-last beat that takes the count to the limit marks an overlength burst.
            if (!sel_last_c && (beat_cnt == BEAT_CNT_W'(AXI_MAX_BEATS - 1))) begin
              protocol_err <= 1'b1;
            end
            if (sel_last_c) begin
              burst_done      <= 1'b1;
              burst_done_port <= cur_port;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
